// File: rtl/ex_stage.sv
// Execute stage of the ezRISC core: ID/EX register with operand forwarding feeding an
// external alu, and an EX/MEM register capturing its result under valid/ready flow control.
module ex_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [3:0]        id_alu_ctrl,
  input  logic [XLEN-1:0]   id_rs1_val,
  input  logic [XLEN-1:0]   id_rs2_val,
  input  logic [XLEN-1:0]   id_imm,
  input  logic              id_use_imm,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  output logic [3:0]        alu_ctrl,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  input  logic [XLEN-1:0]   alu_result,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [XLEN-1:0]   ex_result,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_illegal
);

  typedef struct packed {
    logic [3:0]        ctrl;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic [XLEN-1:0]   imm;
    logic              use_imm;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
  } s1_t;

  s1_t               s1_q, s1_d;
  logic              s1_valid_q;
  logic              ex_valid_q;
  logic [XLEN-1:0]   ex_result_q, ex_result_d;
  logic [REG_AW-1:0] ex_rd_q;
  logic              ex_reg_write_q;
  logic              ex_illegal_q;

  logic legal;
  logic s2_adv;
  logic transfer;

  // A flush squashes the ID/EX slot, so it must neither advance nor block the incoming slot.
  assign s2_adv   = s1_valid_q & (~ex_valid_q | ex_ready) & ~flush;
  assign id_ready = ~s1_valid_q | s2_adv | flush;
  assign transfer = id_valid & id_ready;
  assign legal    = (s1_q.ctrl <= 4'hB);

  assign s1_d = '{ctrl:      id_alu_ctrl,
                  rs1:       id_rs1,
                  rs2:       id_rs2,
                  rs1_val:   id_rs1_val,
                  rs2_val:   id_rs2_val,
                  imm:       id_imm,
                  use_imm:   id_use_imm,
                  rd:        id_rd,
                  reg_write: id_reg_write};

  // The EX/MEM result is younger than writeback, so it wins; x0 is hard-wired and never forwarded.
  function automatic logic [XLEN-1:0] fwd(input logic [REG_AW-1:0] r,
                                          input logic [XLEN-1:0]   rf_val);
    if (r != '0 && ex_valid_q && ex_reg_write_q && ex_rd_q == r) return ex_result_q;
    else if (r != '0 && wb_reg_write && wb_rd == r)              return wb_data;
    else                                                         return rf_val;
  endfunction

  assign alu_ctrl    = s1_q.ctrl;
  assign alu_a       = fwd(s1_q.rs1, s1_q.rs1_val);
  assign alu_b       = s1_q.use_imm ? s1_q.imm : fwd(s1_q.rs2, s1_q.rs2_val);
  assign ex_result_d = legal ? alu_result : '0;

  // NOTE: every register below uses <= so all flops sample pre-edge values together;
  // the payload is reset too because alu_a/alu_b/alu_ctrl are observable straight from it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
    end else if (flush) begin
      s1_valid_q <= 1'b0;
    end else if (transfer) begin
      s1_q       <= s1_d;
      s1_valid_q <= 1'b1;
    end else if (s2_adv) begin
      s1_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid_q     <= 1'b0;
      ex_result_q    <= '0;
      ex_rd_q        <= '0;
      ex_reg_write_q <= 1'b0;
      ex_illegal_q   <= 1'b0;
    end else if (s2_adv) begin
      ex_valid_q     <= 1'b1;
      ex_result_q    <= ex_result_d;
      ex_rd_q        <= s1_q.rd;
      ex_reg_write_q <= s1_q.reg_write & legal;
      ex_illegal_q   <= ~legal;
    end else if (ex_ready) begin
      ex_valid_q     <= 1'b0;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_result    = ex_result_q;
  assign ex_rd        = ex_rd_q;
  assign ex_reg_write = ex_reg_write_q;
  assign ex_illegal   = ex_illegal_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed steps plus random traffic, checked against an
// in-order instruction model that tracks the newest producer of each register.
module tb_ex_stage;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] imm;
    logic        use_imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        we;
  } instr_t;

  logic        clk = 1'b0;
  logic        reset_n, flush, id_valid, id_ready;
  logic [3:0]  id_alu_ctrl;
  logic [31:0] id_rs1_val, id_rs2_val, id_imm;
  logic        id_use_imm, id_reg_write;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_result;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_illegal;

  int tests = 0;
  int fails = 0;

  ex_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_alu_ctrl(id_alu_ctrl), .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val),
    .id_imm(id_imm), .id_use_imm(id_use_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_result(ex_result),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  // Stand-in alu; undefined codes return junk so the stage's zero-forcing is visible.
  function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] a,
                                         input logic [31:0] b);
    case (c)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h5: return a << b[4:0];
      4'h6: return a >> b[4:0];
      4'h7: return $unsigned($signed(a) >>> b[4:0]);
      4'h8: return {31'b0, $signed(a) < $signed(b)};
      4'h9: return {31'b0, a < b};
      4'hA: return ~(a | b);
      4'hB: return b;
      default: return 32'hDEAD_BEEF ^ a;
    endcase
  endfunction

  always_comb alu_result = alu_fn(alu_ctrl, alu_a, alu_b);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Model: the instruction waiting for the alu, and the one already executed.
  logic        m_s1_full, m_s2_full;
  instr_t      m_s1;
  logic [31:0] m_res;
  logic [4:0]  m_rd;
  logic        m_we, m_ill;

  function automatic instr_t mk(input logic [3:0] c, input logic [31:0] v1, input logic [31:0] v2,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic we, input logic ui, input logic [31:0] imm);
    instr_t i;
    i = '{ctrl: c, v1: v1, v2: v2, imm: imm, use_imm: ui, rs1: rs1, rs2: rs2, rd: rd, we: we};
    return i;
  endfunction

  // Newest visible value of register r: executed instruction, then writeback, then register file.
  function automatic logic [31:0] newest(input logic [4:0] r, input logic [31:0] rf);
    if (r == 5'd0) return rf;
    if (m_s2_full && m_we && m_rd == r) return m_res;
    if (wb_reg_write && wb_rd == r) return wb_data;
    return rf;
  endfunction

  task automatic model_reset();
    m_s1_full = 1'b0;
    m_s2_full = 1'b0;
  endtask

  // One clock: drive inputs just after a falling edge, check, update the model, wait a cycle.
  task automatic step(input instr_t in, input logic v, input logic rdy, input logic fl,
                      input logic wwe, input logic [4:0] wrd, input logic [31:0] wd);
    logic        adv, exp_ready;
    logic [31:0] a, b;
    id_alu_ctrl = in.ctrl;   id_rs1_val = in.v1;  id_rs2_val = in.v2;
    id_imm      = in.imm;    id_use_imm = in.use_imm;
    id_rs1      = in.rs1;    id_rs2 = in.rs2;     id_rd = in.rd;  id_reg_write = in.we;
    id_valid = v;  ex_ready = rdy;  flush = fl;
    wb_reg_write = wwe;  wb_rd = wrd;  wb_data = wd;
    #1;
    adv       = m_s1_full && (!m_s2_full || rdy) && !fl;
    exp_ready = !m_s1_full || adv || fl;
    check("id_ready", {31'b0, id_ready}, {31'b0, exp_ready});
    check("ex_valid", {31'b0, ex_valid}, {31'b0, m_s2_full});
    if (m_s2_full) begin
      check("ex_result", ex_result, m_res);
      check("ex_rd", {27'b0, ex_rd}, {27'b0, m_rd});
      check("ex_reg_write", {31'b0, ex_reg_write}, {31'b0, m_we});
      check("ex_illegal", {31'b0, ex_illegal}, {31'b0, m_ill});
    end
    a = newest(m_s1.rs1, m_s1.v1);
    b = m_s1.use_imm ? m_s1.imm : newest(m_s1.rs2, m_s1.v2);
    if (m_s1_full) begin
      check("alu_ctrl", {28'b0, alu_ctrl}, {28'b0, m_s1.ctrl});
      check("alu_a", alu_a, a);
      check("alu_b", alu_b, b);
    end
    if (adv) begin
      m_s2_full = 1'b1;
      m_res     = (m_s1.ctrl < 4'hC) ? alu_fn(m_s1.ctrl, a, b) : 32'h0;
      m_rd      = m_s1.rd;
      m_we      = m_s1.we && (m_s1.ctrl < 4'hC);
      m_ill     = (m_s1.ctrl >= 4'hC);
    end else if (rdy) begin
      m_s2_full = 1'b0;
    end
    if (fl)                   m_s1_full = 1'b0;
    else if (v && exp_ready) begin m_s1 = in; m_s1_full = 1'b1; end
    else if (adv)             m_s1_full = 1'b0;
    @(negedge clk);
  endtask

  instr_t nop, i1, i2;
  logic [31:0] held;

  initial begin
    nop = mk(4'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0);
    model_reset();
    m_s1 = nop;
    reset_n = 1'b0;  id_valid = 1'b1;  ex_ready = 1'b1;  flush = 1'b0;
    id_alu_ctrl = 4'h3;  id_rs1_val = 32'h11;  id_rs2_val = 32'h22;  id_imm = 32'h0;
    id_use_imm = 1'b0;  id_rs1 = 5'd1;  id_rs2 = 5'd2;  id_rd = 5'd3;  id_reg_write = 1'b1;
    wb_reg_write = 1'b0;  wb_rd = 5'd0;  wb_data = 32'h0;

    // Reset held with decode offering an instruction.
    repeat (3) @(negedge clk);
    check("rst_ex_valid", {31'b0, ex_valid}, 32'h0);
    check("rst_ex_result", ex_result, 32'h0);
    check("rst_ex_rd", {27'b0, ex_rd}, 32'h0);
    check("rst_ex_we", {31'b0, ex_reg_write}, 32'h0);
    check("rst_ex_ill", {31'b0, ex_illegal}, 32'h0);
    check("rst_alu_a", alu_a, 32'h0);
    check("rst_alu_b", alu_b, 32'h0);
    check("rst_alu_ctrl", {28'b0, alu_ctrl}, 32'h0);
    reset_n = 1'b1;
    #1;
    check("rst_id_ready", {31'b0, id_ready}, 32'h1);

    // Straight issue of every legal opcode, then all-ones operands.
    for (int c = 0; c < 12; c++)
      step(mk(c[3:0], 32'h0A, 32'h02, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 32'h0), 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    for (int c = 0; c < 12; c++)
      step(mk(c[3:0], 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 32'h0), 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    repeat (2) step(nop, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);

    // Forwarding: EX/MEM result beats a simultaneous writeback to the same register.
    i1 = mk(4'h0, 32'h10, 32'h20, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 32'h0);
    i2 = mk(4'h0, 32'h0, 32'h7, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 32'h0);
    step(i1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    step(i2, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    id_valid = 1'b0;  wb_reg_write = 1'b1;  wb_rd = 5'd5;  wb_data = 32'h1234;
    #1;
    check("fwd_s2_prio", alu_a, 32'h30);
    step(nop, 1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 32'h1234);
    #1;
    check("fwd_i2_result", ex_result, 32'h37);
    step(mk(4'h0, 32'h55, 32'h1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 32'h0), 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 32'h999);
    id_valid = 1'b0;
    #1;
    check("fwd_x0", alu_a, 32'h55);
    step(nop, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 32'h999);
    step(nop, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);

    // Illegal opcode with a register write requested.
    step(mk(4'hD, 32'h3, 32'h4, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 32'h0), 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    step(nop, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    check("ill_flag", {31'b0, ex_illegal}, 32'h1);
    check("ill_we", {31'b0, ex_reg_write}, 32'h0);
    check("ill_result", ex_result, 32'h0);
    step(nop, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);

    // Backpressure: both registers full, downstream stalled for three cycles.
    step(mk(4'h1, 32'h50, 32'h8, 5'd0, 5'd0, 5'd10, 1'b1, 1'b0, 32'h0), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step(mk(4'h3, 32'hF0, 32'h0, 5'd0, 5'd0, 5'd11, 1'b1, 1'b1, 32'h0F), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    held = ex_result;
    for (int k = 0; k < 3; k++)
      step(mk(4'h4, 32'hAA, 32'h55, 5'd10, 5'd0, 5'd12, 1'b1, 1'b0, 32'h0), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    check("bp_hold", ex_result, held);
    repeat (4) step(nop, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);

    // Flush coincident with a decode transfer while EX/MEM holds an older instruction.
    step(mk(4'h0, 32'h100, 32'h1, 5'd0, 5'd0, 5'd13, 1'b1, 1'b0, 32'h0), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step(mk(4'h0, 32'h200, 32'h2, 5'd0, 5'd0, 5'd14, 1'b1, 1'b0, 32'h0), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step(mk(4'h0, 32'h300, 32'h3, 5'd0, 5'd0, 5'd15, 1'b1, 1'b0, 32'h0), 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
    check("flush_i1_kept", ex_result, 32'h101);
    repeat (3) step(nop, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);

    // Random traffic on a small register window to provoke forwarding, stalls and flushes.
    for (int n = 0; n < 600; n++) begin
      instr_t r;
      r = mk(4'($urandom_range(0, 15)), $urandom, $urandom, 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
             1'($urandom), $urandom);
      step(r, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 9) == 0), 1'($urandom), 5'($urandom_range(0, 3)), $urandom);
    end

    // Asynchronous reset in the middle of traffic discards everything at once.
    step(mk(4'h0, 32'h1, 32'h1, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 32'h0), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step(mk(4'h0, 32'h2, 32'h2, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 32'h0), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_ex_valid", {31'b0, ex_valid}, 32'h0);
    check("mid_rst_ex_we", {31'b0, ex_reg_write}, 32'h0);
    check("mid_rst_id_ready", {31'b0, id_ready}, 32'h1);
    model_reset();
    m_s1 = nop;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) step(nop, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute pipeline stage of the ezRISC core; sits directly upstream of the `alu` and drives its `ALU_ctrl`, `A` and `B` inputs.
- Holds decoded operands in an ID/EX register and resolves RAW hazards by operand forwarding.
- Captures the alu result into an EX/MEM register; valid/ready handshakes on both sides.

Parameters:
- XLEN, 32, datapath width; must match the alu.
- REG_AW, 5, register-index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- flush  in  1  squash the instruction held in the ID/EX register.
- id_valid  in  1  decode offers an instruction.
- id_ready  out  1  stage accepts the decode instruction this cycle.
- id_alu_ctrl  in  4  alu operation code.
- id_rs1_val, id_rs2_val  in  XLEN  register-file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_use_imm  in  1  1: B operand = imm; 0: B operand = rs2.
- id_rs1, id_rs2, id_rd  in  REG_AW  source and destination indices.
- id_reg_write  in  1  instruction writes rd.
- alu_ctrl  out  4  to alu `ALU_ctrl`.
- alu_a, alu_b  out  XLEN  to alu `A`, `B`.
- alu_result  in  XLEN  alu combinational result.
- wb_reg_write  in  1  writeback write enable.
- wb_rd  in  REG_AW  writeback destination index.
- wb_data  in  XLEN  writeback data.
- ex_valid  out  1  EX/MEM register holds a valid instruction.
- ex_ready  in  1  downstream accepts.
- ex_result  out  XLEN  latched alu result.
- ex_rd  out  REG_AW  latched destination index.
- ex_reg_write  out  1  latched write enable.
- ex_illegal  out  1  latched illegal-opcode flag.

Behaviour:
- Reset (async, reset_n=0): s1_valid=0; ex_valid=0; ex_result=0; ex_rd=0; ex_reg_write=0; ex_illegal=0; all s1 fields=0. alu_ctrl/alu_a/alu_b are then 0 (they derive from s1).
- Two registers:
  - s1 (ID/EX): ctrl, rs1/rs2 indices, rs1/rs2 values, imm, use_imm, rd, reg_write.
  - s2 (EX/MEM): the ex_* outputs.
- s2_adv = s1_valid & (~ex_valid | ex_ready). On s2_adv, s2 loads:
  - ex_result=alu_result
  - ex_rd=s1.rd
  - ex_reg_write=s1.reg_write & legal
  - ex_illegal=~legal
  - ex_valid=1
- Else if ex_ready: ex_valid←0.
- legal = (ctrl ≤ 0xB). For ctrl 0xC–0xF, ex_result is forced to 0.
- id_ready = ~s1_valid | s2_adv | flush (combinational).
- Transfer (id_valid & id_ready) loads s1 and sets s1_valid=1; otherwise s2_adv clears s1_valid.
- flush=1: s1_valid←0 next edge, regardless of any transfer. An instruction transferred in the same cycle is dropped, and s2_adv is suppressed that cycle. s2 contents are unaffected (they are older).
- Forwarding (combinational, per source operand, index r):
  - if r≠0 & ex_valid & ex_reg_write & ex_rd==r → ex_result;
  - else if r≠0 & wb_reg_write & wb_rd==r → wb_data;
  - else the s1 value.
  - s2 has priority over wb. Register x0 is never forwarded.
- alu_a = fwd(rs1). alu_b = use_imm ? imm : fwd(rs2). alu_ctrl = s1.ctrl.
- Latency: accepted at edge N, ALU evaluates in cycle N+1, ex_valid visible after edge N+1. Throughput 1 instr/cycle when ex_ready=1.
- Backpressure: ex_ready=0 with ex_valid=1 holds s2 and s1 unchanged. id_ready=0 if s1 is full. Forward values are re-evaluated every cycle, so a late wb write is picked up while stalled.
- Reset mid-operation: all in-flight instructions are discarded immediately; no output glitches to 1 after reset asserts.

Test Plan:
- Reset: hold reset_n=0 with id_valid=1 → ex_valid=0, all ex_* =0, id_ready=1 after release.
- Straight issue: ctrl=0x0..0xB, rs1_val=0x0A, rs2_val=0x02, use_imm=0, back-to-back, ex_ready=1 → one ex_valid per cycle, 2-edge latency. Each ex_result equals the alu model for (ctrl, 0x0A, 0x02). Operands 0xFFFFFFFF/0xFFFFFFFF included.
- Forwarding, s2 vs wb:
  - I1 rd=5 result R1, immediately followed by I2 rs1=5 (rs1_val=0) → alu_a=R1.
  - Simultaneously wb_rd=5, wb_data=0x1234 → alu_a still R1 (s2 priority).
  - rs1=0 with wb_rd=0 → alu_a=id_rs1_val.
- Illegal ctrl 0xD, reg_write=1 → ex_illegal=1, ex_reg_write=0, ex_result=0.
- Backpressure: ex_ready=0 for 3 cycles with s1 and s2 full → id_ready=0, ex_* stable. Release → instructions drain in order, none lost or duplicated.
- Flush coincident with an id transfer while s2 holds I1 → I1 still exits, and the flushed and incoming instructions never appear on ex_valid.
